alu_seq: RTL and testbench



---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the datapath controller and alu_seq.
// master = controller side, slave = ALU side.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       alu_op;
  logic [1:0]       condition;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             write;
  logic             compare;
  logic             neg;
  logic             carry_flag;
  logic             zero_flag;

  modport master (
    output in_valid, in1, in2, alu_op, condition, out_ready,
    input  in_ready, out_valid, out, write, compare, neg, carry_flag, zero_flag
  );

  modport slave (
    input  in_valid, in1, in2, alu_op, condition, out_ready,
    output in_ready, out_valid, out, write, compare, neg, carry_flag, zero_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU (ADD/NAND/SUB, optional iterative MUL) with carry/zero flags and
// flag-conditioned writes. Define ALU_SEQ_MUL_EN to build the shift-add multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic {S_IDLE, S_MUL} state_t;
`else
  typedef enum logic {S_IDLE} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_write;
  logic             r_compare;
  logic             r_carry;
  logic             r_zero;

  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_z;
  logic             w_eq;
  logic             w_cond_ok;
  logic             w_wr;
  logic             w_in_ready;
  logic             w_accept;

`ifdef ALU_SEQ_MUL_EN
  logic [W2-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [W2-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_mul_wr;
  logic             r_mul_eq;
  logic [W2-1:0]    w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  // Single-cycle result; NAND (and unbuilt MUL) pass the current carry through
  always_comb begin
    w_res = '0;
    w_c   = r_carry;
    case (bus.alu_op)
      OP_ADD:  {w_c, w_res} = {1'b0, bus.in1} + {1'b0, bus.in2};
      OP_SUB:  {w_c, w_res} = {1'b0, bus.in1} + {1'b0, ~bus.in2} + W1'(1);
      OP_NAND: w_res = ~(bus.in1 & bus.in2);
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_cond_ok = 1'b0;
    case (bus.condition)
      2'b00:   w_cond_ok = 1'b1;
      2'b01:   w_cond_ok = r_zero;
      2'b10:   w_cond_ok = r_carry;
      default: w_cond_ok = 1'b0;
    endcase
  end

  assign w_z        = (w_res == '0);
  assign w_eq       = (bus.in1 == bus.in2);
  assign w_wr       = w_cond_ok && (bus.alu_op != OP_MUL);
  assign w_in_ready = !reset && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_write     <= 1'b0;
      r_compare   <= 1'b0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mul_wr    <= 1'b0;
      r_mul_eq    <= 1'b0;
`endif
    end else begin
      // Drain by default; a completion in the same edge overrides this
      if (bus.out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (bus.alu_op == OP_MUL) begin
              r_state  <= S_MUL;
              r_mcand  <= W2'(bus.in1);
              r_mplier <= bus.in2;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_mul_wr <= w_cond_ok;
              r_mul_eq <= w_eq;
            end else begin
`else
            begin
`endif
              r_out       <= w_res;
              r_out_valid <= 1'b1;
              r_write     <= w_wr;
              r_compare   <= w_eq;
              if (w_wr) begin
                r_carry <= w_c;
                r_zero  <= w_z;
              end
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        // One multiplier bit per edge; the last iteration edge is the completion load
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state     <= S_IDLE;
            r_out       <= w_acc_nxt[WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_write     <= r_mul_wr;
            r_compare   <= r_mul_eq;
            if (r_mul_wr) begin
              r_carry <= |w_acc_nxt[W2-1:WIDTH];
              r_zero  <= (w_acc_nxt[WIDTH-1:0] == '0);
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out        = r_out;
  assign bus.write      = r_write;
  assign bus.compare    = r_compare;
  assign bus.neg        = r_out[WIDTH-1];
  assign bus.carry_flag = r_carry;
  assign bus.zero_flag  = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table plus back-pressure, multiply/op-11 and reset sequences,
// with results checked through an expected-result queue.
module tb_alu_seq;
  localparam int unsigned WIDTH = 16;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;
  localparam int NV = 12;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  cond;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e_out;
    logic        e_wr;
    logic        e_cmp;
    logic        e_c;
    logic        e_z;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        wr;
    logic        cmp;
    logic        c;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  vec_t vt[NV];

  alu_seq_if #(.WIDTH(WIDTH)) bus();
  alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Result monitor: every transfer is compared against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output out=%0h", bus.out);
      end else begin
        e = sb.pop_front();
        check("out",        32'(bus.out),        32'(e.out));
        check("write",      32'(bus.write),      32'(e.wr));
        check("compare",    32'(bus.compare),    32'(e.cmp));
        check("neg",        32'(bus.neg),        32'(e.out[15]));
        check("carry_flag", 32'(bus.carry_flag), 32'(e.c));
        check("zero_flag",  32'(bus.zero_flag),  32'(e.z));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [1:0] cond, input logic [15:0] a,
                       input logic [15:0] b, input exp_t e, output int waited);
    bus.in_valid  = 1'b1;
    bus.alu_op    = op;
    bus.condition = cond;
    bus.in1       = a;
    bus.in2       = b;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout op=%0d waited=%0d", op, waited);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic measure(output int lat, output int rdy_seen);
    lat = 0;
    rdy_seen = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int lat;
    int rdy;
    int seen;

    //             op       cond   a         b         out       wr    cmp   c     z
    vt[0]  = '{OP_ADD,  2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[1]  = '{OP_ADD,  2'b10, 16'h0003, 16'h0004, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{OP_ADD,  2'b10, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{OP_SUB,  2'b00, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[4]  = '{OP_NAND, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{OP_ADD,  2'b01, 16'h1234, 16'h0001, 16'h1235, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{OP_ADD,  2'b01, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{OP_SUB,  2'b00, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{OP_SUB,  2'b00, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{OP_ADD,  2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[10] = '{OP_NAND, 2'b10, 16'hF0F0, 16'h0FF0, 16'hFF0F, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = '{OP_ADD,  2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.alu_op    = OP_ADD;
    bus.condition = 2'b00;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out",       32'(bus.out),        32'd0);
    check("rst_out_valid", 32'(bus.out_valid),  32'd0);
    check("rst_write",     32'(bus.write),      32'd0);
    check("rst_compare",   32'(bus.compare),    32'd0);
    check("rst_neg",       32'(bus.neg),        32'd0);
    check("rst_carry",     32'(bus.carry_flag), 32'd0);
    check("rst_zero",      32'(bus.zero_flag),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back vector table
    for (int i = 0; i < NV; i++) begin
      issue(vt[i].op, vt[i].cond, vt[i].a, vt[i].b,
            '{vt[i].e_out, vt[i].e_wr, vt[i].e_cmp, vt[i].e_c, vt[i].e_z}, w);
      check("table_accept_wait", 32'(w), 32'd0);
    end
    drain();

    // Back-pressure: result held, second op stalled until out_ready
    bus.out_ready = 1'b0;
    issue(OP_ADD, 2'b00, 16'h1234, 16'h0001, '{16'h1235, 1'b1, 1'b0, 1'b0, 1'b0}, w);
    bus.in_valid = 1'b1;
    bus.alu_op   = OP_ADD;
    bus.in1      = 16'h0002;
    bus.in2      = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out",       32'(bus.out),       32'h1235);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(OP_ADD, 2'b00, 16'h0002, 16'h0003, '{16'h0005, 1'b1, 1'b0, 1'b0, 1'b0}, w);
    check("bp_release_wait", 32'(w), 32'd0);
    drain();

`ifdef ALU_SEQ_MUL_EN
    issue(OP_MUL, 2'b00, 16'h0003, 16'h0005, '{16'h000F, 1'b1, 1'b0, 1'b0, 1'b0}, w);
    measure(lat, rdy);
    check("mul_latency", 32'(lat), 32'd16);
    check("mul_in_ready_busy", 32'(rdy), 32'd0);
    drain();
    issue(OP_MUL, 2'b00, 16'h0100, 16'h0100, '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b1}, w);
    drain();

    // Reset during the fifth multiply iteration
    issue(OP_MUL, 2'b00, 16'h0007, 16'h0009, '{16'h003F, 1'b1, 1'b0, 1'b0, 1'b0}, w);
    check("pre_reset_carry", 32'(bus.carry_flag), 32'd1);
    repeat (4) @(posedge clk);
    #1;
`else
    issue(OP_MUL, 2'b00, 16'h0003, 16'h0005, '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}, w);
    measure(lat, rdy);
    check("op11_latency", 32'(lat), 32'd0);
    drain();

    // Reset with a result parked in the output buffer
    bus.out_ready = 1'b0;
    issue(OP_ADD, 2'b00, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}, w);
    @(negedge clk);
    check("pre_reset_carry", 32'(bus.carry_flag), 32'd1);
    @(posedge clk);
    #1;
`endif
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_out_valid", 32'(bus.out_valid),  32'd0);
    check("mid_reset_carry",     32'(bus.carry_flag), 32'd0);
    check("mid_reset_zero",      32'(bus.zero_flag),  32'd0);
    check("mid_reset_in_ready",  32'(bus.in_ready),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no_stale_result", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
